// File: rtl/tsn_md_buffer.sv
// Metadata buffer: four independent show-ahead FIFOs that hold per-class TSN metadata
// between queue selection and the gate-control scheduler.

module tsn_md_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [W-1:0]  data_i,
  input  logic          rd_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   usedw_o,
  output logic [15:0]   drop_cnt_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   usedw_q, usedw_d;
  logic [15:0]   drop_q, drop_d;
  logic          empty_q, full_q;
  logic          valid_q;
  logic          fwd_q, fwd_d;
  logic [W-1:0]  fwd_data_q;
  logic [W-1:0]  ram_q;
  logic          wr_ok, pop_ok, drop;

  always_comb begin
    // A full queue still takes a write when the same cycle pops it.
    wr_ok  = wr_i && (!full_q || rd_i);
    pop_ok = rd_i && !empty_q;
    drop   = wr_i && full_q && !rd_i;

    wr_ptr_d = wr_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;

    usedw_d = usedw_q;
    if (wr_ok && !pop_ok) begin
      usedw_d = usedw_q + (AW+1)'(1);
    end else if (!wr_ok && pop_ok) begin
      usedw_d = usedw_q - (AW+1)'(1);
    end

    drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

    // The freshly written word becomes the head only when it is the sole entry left;
    // RAM cannot supply it yet, so take it straight from the input.
    fwd_d = wr_ok && ((usedw_q == '0) || ((usedw_q == (AW+1)'(1)) && pop_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      drop_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      fwd_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      drop_q   <= drop_d;
      empty_q  <= (usedw_d == '0);
      full_q   <= (usedw_d == (AW+1)'(DEPTH));
      valid_q  <= (usedw_d != '0);
      fwd_q    <= fwd_d;
    end
  end

  // Storage and its registered read port carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr_q] <= data_i;
    end
    ram_q      <= mem[rd_ptr_d];
    fwd_data_q <= data_i;
  end

  assign head_o     = valid_q ? (fwd_q ? fwd_data_q : ram_q) : '0;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign usedw_o    = usedw_q;
  assign drop_cnt_o = drop_q;

endmodule

module tsn_md_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    in_mb_md0,
  input  logic          in_mb_md0_wr,
  input  logic [8:0]    in_mb_md1,
  input  logic          in_mb_md1_wr,
  input  logic [19:0]   in_mb_md2,
  input  logic          in_mb_md2_wr,
  input  logic [8:0]    in_mb_md3,
  input  logic          in_mb_md3_wr,
  input  logic [3:0]    in_mb_rd,
  output logic [8:0]    out_mb_md0,
  output logic [8:0]    out_mb_md1,
  output logic [19:0]   out_mb_md2,
  output logic [8:0]    out_mb_md3,
  output logic [3:0]    out_mb_empty,
  output logic [3:0]    out_mb_full,
  output logic [AW:0]   out_mb_usedw0,
  output logic [AW:0]   out_mb_usedw1,
  output logic [AW:0]   out_mb_usedw2,
  output logic [AW:0]   out_mb_usedw3,
  output logic [15:0]   out_mb_drop_cnt0,
  output logic [15:0]   out_mb_drop_cnt1,
  output logic [15:0]   out_mb_drop_cnt2,
  output logic [15:0]   out_mb_drop_cnt3
);

  tsn_md_fifo #(.W(9), .DEPTH(DEPTH), .AW(AW)) u_q0 (
    .clk(clk), .rst(rst), .wr_i(in_mb_md0_wr), .data_i(in_mb_md0), .rd_i(in_mb_rd[0]),
    .head_o(out_mb_md0), .empty_o(out_mb_empty[0]), .full_o(out_mb_full[0]),
    .usedw_o(out_mb_usedw0), .drop_cnt_o(out_mb_drop_cnt0)
  );

  tsn_md_fifo #(.W(9), .DEPTH(DEPTH), .AW(AW)) u_q1 (
    .clk(clk), .rst(rst), .wr_i(in_mb_md1_wr), .data_i(in_mb_md1), .rd_i(in_mb_rd[1]),
    .head_o(out_mb_md1), .empty_o(out_mb_empty[1]), .full_o(out_mb_full[1]),
    .usedw_o(out_mb_usedw1), .drop_cnt_o(out_mb_drop_cnt1)
  );

  // Q2 carries token length alongside the port/queue info, hence the wider word.
  tsn_md_fifo #(.W(20), .DEPTH(DEPTH), .AW(AW)) u_q2 (
    .clk(clk), .rst(rst), .wr_i(in_mb_md2_wr), .data_i(in_mb_md2), .rd_i(in_mb_rd[2]),
    .head_o(out_mb_md2), .empty_o(out_mb_empty[2]), .full_o(out_mb_full[2]),
    .usedw_o(out_mb_usedw2), .drop_cnt_o(out_mb_drop_cnt2)
  );

  tsn_md_fifo #(.W(9), .DEPTH(DEPTH), .AW(AW)) u_q3 (
    .clk(clk), .rst(rst), .wr_i(in_mb_md3_wr), .data_i(in_mb_md3), .rd_i(in_mb_rd[3]),
    .head_o(out_mb_md3), .empty_o(out_mb_empty[3]), .full_o(out_mb_full[3]),
    .usedw_o(out_mb_usedw3), .drop_cnt_o(out_mb_drop_cnt3)
  );

endmodule

// File: tb/tb_tsn_md_buffer.sv
// Directed self-checking bench for tsn_md_buffer: ordering, overflow drops,
// underflow, same-cycle forwarding, pointer wrap and mid-operation reset.

module tb_tsn_md_buffer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [8:0]    in_mb_md0, in_mb_md1, in_mb_md3;
  logic [19:0]   in_mb_md2;
  logic          in_mb_md0_wr, in_mb_md1_wr, in_mb_md2_wr, in_mb_md3_wr;
  logic [3:0]    in_mb_rd;
  logic [8:0]    out_mb_md0, out_mb_md1, out_mb_md3;
  logic [19:0]   out_mb_md2;
  logic [3:0]    out_mb_empty, out_mb_full;
  logic [AW:0]   out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3;
  logic [15:0]   out_mb_drop_cnt0, out_mb_drop_cnt1, out_mb_drop_cnt2, out_mb_drop_cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tsn_md_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_mb_md0(in_mb_md0), .in_mb_md0_wr(in_mb_md0_wr),
    .in_mb_md1(in_mb_md1), .in_mb_md1_wr(in_mb_md1_wr),
    .in_mb_md2(in_mb_md2), .in_mb_md2_wr(in_mb_md2_wr),
    .in_mb_md3(in_mb_md3), .in_mb_md3_wr(in_mb_md3_wr),
    .in_mb_rd(in_mb_rd),
    .out_mb_md0(out_mb_md0), .out_mb_md1(out_mb_md1),
    .out_mb_md2(out_mb_md2), .out_mb_md3(out_mb_md3),
    .out_mb_empty(out_mb_empty), .out_mb_full(out_mb_full),
    .out_mb_usedw0(out_mb_usedw0), .out_mb_usedw1(out_mb_usedw1),
    .out_mb_usedw2(out_mb_usedw2), .out_mb_usedw3(out_mb_usedw3),
    .out_mb_drop_cnt0(out_mb_drop_cnt0), .out_mb_drop_cnt1(out_mb_drop_cnt1),
    .out_mb_drop_cnt2(out_mb_drop_cnt2), .out_mb_drop_cnt3(out_mb_drop_cnt3)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_mb_md0_wr = 1'b0; in_mb_md1_wr = 1'b0; in_mb_md2_wr = 1'b0; in_mb_md3_wr = 1'b0;
    in_mb_rd = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_mb_md0 = '0; in_mb_md1 = '0; in_mb_md2 = '0; in_mb_md3 = '0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if (out_mb_empty !== 4'hF) begin
      n_err++; $display("FAIL reset_empty: got %h expected F", out_mb_empty);
    end
    n_cmp++;
    if (out_mb_full !== 4'h0) begin
      n_err++; $display("FAIL reset_full: got %h expected 0", out_mb_full);
    end
    n_cmp++;
    if ({out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3} !== 28'd0) begin
      n_err++; $display("FAIL reset_usedw: got %0d %0d %0d %0d expected all 0",
                        out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3);
    end
    n_cmp++;
    if ({out_mb_md0, out_mb_md1, out_mb_md2, out_mb_md3} !== 47'd0) begin
      n_err++; $display("FAIL reset_heads: got %h %h %h %h expected all 0",
                        out_mb_md0, out_mb_md1, out_mb_md2, out_mb_md3);
    end
    n_cmp++;
    if ({out_mb_drop_cnt0, out_mb_drop_cnt1, out_mb_drop_cnt2, out_mb_drop_cnt3} !== 64'd0) begin
      n_err++; $display("FAIL reset_drops: got nonzero drop counters");
    end
    $display("reset: empty=%h full=%h", out_mb_empty, out_mb_full);
  endtask

  task automatic test_single_write();
    in_mb_md3 = 9'h1A5; in_mb_md3_wr = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_mb_md3 !== 9'h1A5) begin
      n_err++; $display("FAIL single_head3: got %h expected 1a5", out_mb_md3);
    end
    n_cmp++;
    if (out_mb_empty !== 4'h7) begin
      n_err++; $display("FAIL single_empty: got %h expected 7", out_mb_empty);
    end
    n_cmp++;
    if (out_mb_usedw3 !== 7'd1) begin
      n_err++; $display("FAIL single_usedw3: got %0d expected 1", out_mb_usedw3);
    end
    n_cmp++;
    if ({out_mb_md0, out_mb_md1, out_mb_md2, out_mb_usedw0, out_mb_usedw1, out_mb_usedw2} !== 59'd0) begin
      n_err++; $display("FAIL single_others: other queues disturbed");
    end
    $display("single write q3: head=%h usedw3=%0d", out_mb_md3, out_mb_usedw3);
    in_mb_rd = 4'h8;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_mb_empty !== 4'hF || out_mb_md3 !== 9'h000) begin
      n_err++; $display("FAIL single_pop: got empty=%h head3=%h expected F/000", out_mb_empty, out_mb_md3);
    end
  endtask

  task automatic test_q2_order();
    logic [19:0] wdata [3];
    logic [19:0] exp_head [3];
    logic [6:0]  exp_used [3];
    wdata    = '{20'hABCDE, 20'h00123, 20'h7FFFF};
    exp_head = '{20'h00123, 20'h7FFFF, 20'h00000};
    exp_used = '{7'd2, 7'd1, 7'd0};
    for (int i = 0; i < 3; i++) begin
      in_mb_md2 = wdata[i]; in_mb_md2_wr = 1'b1;
      tick();
      n_cmp++;
      if (out_mb_md2 !== 20'hABCDE) begin
        n_err++; $display("FAIL q2_fill_head[%0d]: got %h expected abcde", i, out_mb_md2);
      end
    end
    idle_inputs();
    n_cmp++;
    if (out_mb_usedw2 !== 7'd3) begin
      n_err++; $display("FAIL q2_usedw: got %0d expected 3", out_mb_usedw2);
    end
    for (int i = 0; i < 3; i++) begin
      in_mb_rd = 4'h4;
      tick();
      in_mb_rd = 4'h0;
      n_cmp++;
      if (out_mb_md2 !== exp_head[i] || out_mb_usedw2 !== exp_used[i]) begin
        n_err++; $display("FAIL q2_pop[%0d]: got head=%h usedw=%0d expected %h/%0d",
                          i, out_mb_md2, out_mb_usedw2, exp_head[i], exp_used[i]);
      end
      $display("q2 pop %0d: head=%h usedw2=%0d", i, out_mb_md2, out_mb_usedw2);
    end
    n_cmp++;
    if (out_mb_empty[2] !== 1'b1) begin
      n_err++; $display("FAIL q2_empty: got %b expected 1", out_mb_empty[2]);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      in_mb_md0 = 9'(i + 1); in_mb_md0_wr = 1'b1;
      tick();
    end
    n_cmp++;
    if (out_mb_full[0] !== 1'b1 || out_mb_usedw0 !== 7'd64 || out_mb_md0 !== 9'd1) begin
      n_err++; $display("FAIL ovf_filled: got full=%b usedw=%0d head=%h expected 1/64/001",
                        out_mb_full[0], out_mb_usedw0, out_mb_md0);
    end
    for (int i = 0; i < 3; i++) begin
      in_mb_md0 = 9'h155;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (out_mb_drop_cnt0 !== 16'd3 || out_mb_usedw0 !== 7'd64) begin
      n_err++; $display("FAIL ovf_drops: got drop=%0d usedw=%0d expected 3/64", out_mb_drop_cnt0, out_mb_usedw0);
    end
    $display("q0 overflow: drop_cnt0=%0d usedw0=%0d", out_mb_drop_cnt0, out_mb_usedw0);
    in_mb_md0 = 9'h1FF; in_mb_md0_wr = 1'b1; in_mb_rd = 4'h1;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_mb_usedw0 !== 7'd64 || out_mb_drop_cnt0 !== 16'd3 || out_mb_full[0] !== 1'b1 || out_mb_md0 !== 9'd2) begin
      n_err++; $display("FAIL ovf_wr_pop: got usedw=%0d drop=%0d full=%b head=%h expected 64/3/1/002",
                        out_mb_usedw0, out_mb_drop_cnt0, out_mb_full[0], out_mb_md0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? 9'(i + 2) : 9'h1FF;
      n_cmp++;
      if (out_mb_md0 !== exp) begin
        n_err++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, out_mb_md0, exp);
      end
      in_mb_rd = 4'h1;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (out_mb_empty[0] !== 1'b1 || out_mb_usedw0 !== 7'd0) begin
      n_err++; $display("FAIL ovf_drained: got empty=%b usedw=%0d expected 1/0", out_mb_empty[0], out_mb_usedw0);
    end
  endtask

  task automatic test_underflow_fwd();
    in_mb_rd = 4'h2;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_mb_usedw1 !== 7'd0 || out_mb_empty[1] !== 1'b1 || out_mb_md1 !== 9'd0) begin
        n_err++; $display("FAIL underflow[%0d]: got usedw=%0d empty=%b head=%h expected 0/1/000",
                          i, out_mb_usedw1, out_mb_empty[1], out_mb_md1);
      end
    end
    in_mb_md1 = 9'h0AB; in_mb_md1_wr = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_mb_usedw1 !== 7'd1 || out_mb_md1 !== 9'h0AB || out_mb_empty[1] !== 1'b0) begin
      n_err++; $display("FAIL empty_wr_pop: got usedw=%0d head=%h empty=%b expected 1/0ab/0",
                        out_mb_usedw1, out_mb_md1, out_mb_empty[1]);
    end
    in_mb_md1 = 9'h0CD; in_mb_md1_wr = 1'b1; in_mb_rd = 4'h2;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_mb_usedw1 !== 7'd1 || out_mb_md1 !== 9'h0CD) begin
      n_err++; $display("FAIL single_fwd: got usedw=%0d head=%h expected 1/0cd", out_mb_usedw1, out_mb_md1);
    end
    $display("q1 forward: head=%h usedw1=%0d", out_mb_md1, out_mb_usedw1);
    in_mb_rd = 4'h2;
    tick();
    idle_inputs();
  endtask

  task automatic test_wrap_q3();
    for (int k = 0; k < 3; k++) begin
      in_mb_md3 = 9'(k); in_mb_md3_wr = 1'b1;
      tick();
    end
    for (int k = 3; k < 203; k++) begin
      in_mb_md3 = 9'(k); in_mb_md3_wr = 1'b1; in_mb_rd = 4'h8;
      tick();
      n_cmp++;
      if (out_mb_md3 !== 9'(k - 2)) begin
        n_err++; $display("FAIL wrap[%0d]: got %h expected %h", k, out_mb_md3, 9'(k - 2));
      end
    end
    idle_inputs();
    n_cmp++;
    if (out_mb_usedw3 !== 7'd3) begin
      n_err++; $display("FAIL wrap_usedw: got %0d expected 3", out_mb_usedw3);
    end
    for (int k = 200; k < 203; k++) begin
      n_cmp++;
      if (out_mb_md3 !== 9'(k)) begin
        n_err++; $display("FAIL wrap_drain[%0d]: got %h expected %h", k, out_mb_md3, 9'(k));
      end
      in_mb_rd = 4'h8;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (out_mb_empty !== 4'hF) begin
      n_err++; $display("FAIL wrap_empty: got %h expected F", out_mb_empty);
    end
    $display("q3 wrap: 203 entries streamed, empty=%h", out_mb_empty);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < DEPTH / 2; i++) begin
      in_mb_md0 = 9'(i); in_mb_md1 = 9'(i); in_mb_md2 = 20'(i); in_mb_md3 = 9'(i);
      in_mb_md0_wr = 1'b1; in_mb_md1_wr = 1'b1; in_mb_md2_wr = 1'b1; in_mb_md3_wr = 1'b1;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if ({out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3} !== {4{7'd32}}) begin
      n_err++; $display("FAIL half_full: got %0d %0d %0d %0d expected 32 each",
                        out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3);
    end
    rst = 1'b1;
    in_mb_md0_wr = 1'b1; in_mb_md1_wr = 1'b1; in_mb_md2_wr = 1'b1; in_mb_md3_wr = 1'b1;
    in_mb_rd = 4'hF;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_cmp++;
    if ({out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3} !== 28'd0) begin
      n_err++; $display("FAIL midrst_usedw: got %0d %0d %0d %0d expected all 0",
                        out_mb_usedw0, out_mb_usedw1, out_mb_usedw2, out_mb_usedw3);
    end
    n_cmp++;
    if (out_mb_empty !== 4'hF || out_mb_full !== 4'h0) begin
      n_err++; $display("FAIL midrst_flags: got empty=%h full=%h expected F/0", out_mb_empty, out_mb_full);
    end
    n_cmp++;
    if (out_mb_drop_cnt0 !== 16'd0 || out_mb_drop_cnt3 !== 16'd0) begin
      n_err++; $display("FAIL midrst_drops: got drop0=%0d drop3=%0d expected 0/0", out_mb_drop_cnt0, out_mb_drop_cnt3);
    end
    n_cmp++;
    if ({out_mb_md0, out_mb_md1, out_mb_md2, out_mb_md3} !== 47'd0) begin
      n_err++; $display("FAIL midrst_heads: got %h %h %h %h expected all 0",
                        out_mb_md0, out_mb_md1, out_mb_md2, out_mb_md3);
    end
    in_mb_md3 = 9'h1A5; in_mb_md3_wr = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (out_mb_md3 !== 9'h1A5 || out_mb_empty !== 4'h7 || out_mb_usedw3 !== 7'd1) begin
      n_err++; $display("FAIL midrst_write: got head=%h empty=%h usedw=%0d expected 1a5/7/1",
                        out_mb_md3, out_mb_empty, out_mb_usedw3);
    end
    $display("mid-op reset: then q3 head=%h usedw3=%0d", out_mb_md3, out_mb_usedw3);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_q2_order();
    test_overflow();
    test_underflow_fwd();
    test_wrap_q3();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
